// File: rtl/stopwatch_timer_ctrl_if.sv
// Command/status bundle between the button layer and the stopwatch controller.
// master drives commands; slave (the controller) returns count and status.
interface stopwatch_timer_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic             stop;
   logic             clear;
   logic             lap;
   logic             down_mode;
   logic [CNT_W-1:0] load_val;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] lap_val;
   logic             lap_valid;
   logic             done;
   logic [1:0]       status;
   logic             c_enable;

   modport master (
      output start, stop, clear, lap, down_mode, load_val,
      input  count, lap_val, lap_valid, done, status, c_enable
   );

   modport slave (
      input  start, stop, clear, lap, down_mode, load_val,
      output count, lap_val, lap_valid, done, status, c_enable
   );
endinterface

// File: rtl/stopwatch_timer_ctrl.sv
// Stopwatch/timer control: IDLE/RUNNING/PAUSED/DONE FSM with a prescaled
// up/down counter, terminal-count done pulse and lap capture.
module stopwatch_timer_ctrl #(
   parameter int CNT_W    = 16,
   parameter int TICK_DIV = 10
) (
   input  logic clk,
   input  logic rst,
   stopwatch_timer_ctrl_if.slave bus
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] ALL1     = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_lap_val;
   logic [PW-1:0]    r_pre;
   logic             r_mode;
   logic             r_lap_valid;
   logic             r_done;

   logic             w_tick;
   logic             w_step;
   logic [CNT_W-1:0] w_step_val;
   logic             w_term;
   logic             w_zero_load;
   logic             w_lap_ok;
   logic             w_c_enable;
   logic [1:0]       w_status;

   assign w_tick      = (r_pre == PRE_LAST);
   assign w_step      = (r_state == S_RUN) && !bus.stop && w_tick;
   assign w_step_val  = r_mode ? (r_count - CNT_W'(1))
                               : (r_count + CNT_W'(1));
   assign w_term      = r_mode ? (w_step_val == '0)
                               : (w_step_val == ALL1);
   assign w_zero_load = bus.down_mode && (bus.load_val == '0);
   assign w_lap_ok    = (r_state == S_RUN) || (r_state == S_PAUSE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (bus.start) w_next = w_zero_load ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (bus.stop)                w_next = S_PAUSE;
            else if (w_step && w_term)   w_next = S_DONE;
         end
         S_PAUSE: begin
            if (bus.start)               w_next = S_RUN;
            else if (bus.clear)          w_next = S_IDLE;
         end
         S_DONE: begin
            if (bus.clear)               w_next = S_IDLE;
         end
      endcase
   end

   always_comb begin
      w_c_enable = (r_state == S_RUN);
      w_status   = r_state;
   end

   // Stop pauses before the prescaler advances, so a resume finishes the
   // partial period that was in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count     <= '0;
         r_lap_val   <= '0;
         r_pre       <= '0;
         r_mode      <= 1'b0;
         r_lap_valid <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done      <= (w_next == S_DONE) && (r_state != S_DONE);
         r_lap_valid <= 1'b0;
         if (w_lap_ok && bus.lap) begin
            r_lap_val   <= r_count;
            r_lap_valid <= 1'b1;
         end
         unique case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_mode  <= bus.down_mode;
                  r_count <= bus.down_mode ? bus.load_val : '0;
                  r_pre   <= '0;
               end
            end
            S_RUN: begin
               if (!bus.stop) begin
                  if (w_tick) begin
                     r_pre   <= '0;
                     r_count <= w_step_val;
                  end else begin
                     r_pre   <= r_pre + PW'(1);
                  end
               end
            end
            S_PAUSE: begin
               if (!bus.start && bus.clear) begin
                  r_count <= '0;
                  r_pre   <= '0;
               end
            end
            S_DONE: begin
               if (bus.clear) begin
                  r_count <= '0;
                  r_pre   <= '0;
               end
            end
         endcase
      end
   end

   assign bus.count     = r_count;
   assign bus.lap_val   = r_lap_val;
   assign bus.lap_valid = r_lap_valid;
   assign bus.done      = r_done;
   assign bus.status    = w_status;
   assign bus.c_enable  = w_c_enable;
endmodule

// File: tb/tb_stopwatch_timer_ctrl.sv
// Bench for stopwatch_timer_ctrl: directed scenarios with literal
// expectations, then random commands checked against a behavioural model.
module tb_stopwatch_timer_ctrl;
   localparam int CW   = 4;
   localparam int TD   = 10;
   localparam int MAXC = (1 << CW) - 1;
   localparam int IDLE = 0, RUN = 1, PAUSED = 2, DONE = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   stopwatch_timer_ctrl_if #(.CNT_W(CW)) sw ();

   stopwatch_timer_ctrl #(.CNT_W(CW), .TICK_DIV(TD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sw)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t",
                    nm, act, exp, $time);
   endtask

   // Behavioural model: state, count, position within tick period, lap.
   int m_st, m_cnt, m_pre, m_lap, m_lv, m_done, m_mode;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_st = IDLE; m_cnt = 0; m_pre = 0; m_lap = 0;
         m_lv = 0; m_done = 0; m_mode = 0;
      end else begin
         m_lv   = 0;
         m_done = 0;
         if ((m_st == RUN || m_st == PAUSED) && sw.lap) begin
            m_lap = m_cnt;
            m_lv  = 1;
         end
         case (m_st)
            IDLE: if (sw.start) begin
               m_mode = sw.down_mode;
               m_pre  = 0;
               m_cnt  = sw.down_mode ? int'(sw.load_val) : 0;
               if (sw.down_mode && sw.load_val == 0) begin
                  m_st = DONE; m_done = 1;
               end else m_st = RUN;
            end
            RUN: if (sw.stop) m_st = PAUSED;
            else begin
               m_pre++;
               if (m_pre == TD) begin
                  m_pre = 0;
                  m_cnt = m_mode ? m_cnt - 1 : m_cnt + 1;
                  if (m_cnt == (m_mode ? 0 : MAXC)) begin
                     m_st = DONE; m_done = 1;
                  end
               end
            end
            PAUSED: if (sw.start) m_st = RUN;
            else if (sw.clear) begin
               m_st = IDLE; m_cnt = 0; m_pre = 0;
            end
            default: if (sw.clear) begin
               m_st = IDLE; m_cnt = 0; m_pre = 0;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      chk("status",    sw.status,    m_st);
      chk("count",     sw.count,     m_cnt);
      chk("lap_val",   sw.lap_val,   m_lap);
      chk("lap_valid", sw.lap_valid, m_lv);
      chk("done",      sw.done,      m_done);
      chk("c_enable",  sw.c_enable,  int'(m_st == RUN));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      sw.start = 0; sw.stop = 0; sw.clear = 0; sw.lap = 0;
      sw.down_mode = 0; sw.load_val = '0;
      #1 rst = 1;
      @(negedge clk);
      chk("rst_status", sw.status, 0);
      chk("rst_count", sw.count, 0);
      rst = 0;

      sw.start = 1; tick(1); sw.start = 0;
      chk("up_status", sw.status, 1);
      chk("up_cen", sw.c_enable, 1);
      tick(30);
      chk("up_count3", sw.count, 3);

      tick(4); sw.stop = 1; tick(1); sw.stop = 0;
      chk("pause_status", sw.status, 2);
      tick(20);
      chk("pause_frozen", sw.count, 3);
      sw.start = 1; tick(1); sw.start = 0;
      chk("resume_status", sw.status, 1);
      tick(5);
      chk("resume_5", sw.count, 3);
      tick(1);
      chk("resume_6", sw.count, 4);

      tick(9); sw.stop = 1; tick(1); sw.stop = 0;
      chk("stop_on_step", sw.count, 4);
      sw.start = 1; sw.clear = 1; tick(1); sw.start = 0; sw.clear = 0;
      chk("start_beats_clear", sw.status, 1);
      tick(1);
      chk("partial_resume", sw.count, 5);

      tick(20);
      sw.lap = 1; tick(1); sw.lap = 0;
      chk("lap_val7", sw.lap_val, 7);
      chk("lap_pulse", sw.lap_valid, 1);
      tick(1);
      chk("lap_pulse_end", sw.lap_valid, 0);
      tick(8);
      chk("lap_no_interrupt", sw.count, 8);

      sw.stop = 1; tick(1); sw.stop = 0;
      sw.clear = 1; tick(1); sw.clear = 0;
      chk("clear_status", sw.status, 0);
      chk("clear_count", sw.count, 0);
      sw.lap = 1; tick(1); sw.lap = 0;
      chk("idle_lap_pulse", sw.lap_valid, 0);
      chk("idle_lap_keep", sw.lap_val, 7);

      sw.down_mode = 1; sw.load_val = 4'd5;
      sw.start = 1; tick(1); sw.start = 0;
      sw.down_mode = 0; sw.load_val = '0;
      chk("down_load", sw.count, 5);
      for (int k = 4; k >= 1; k--) begin
         tick(10);
         chk("down_step", sw.count, k);
      end
      tick(10);
      chk("down_zero", sw.count, 0);
      chk("down_done_st", sw.status, 3);
      chk("down_done_pulse", sw.done, 1);
      tick(1);
      chk("down_done_end", sw.done, 0);
      sw.start = 1; tick(1); sw.start = 0;
      chk("done_ignore_start", sw.status, 3);
      sw.clear = 1; tick(1); sw.clear = 0;
      chk("done_clear", sw.status, 0);

      sw.down_mode = 1; sw.start = 1; tick(1);
      sw.start = 0; sw.down_mode = 0;
      chk("load0_status", sw.status, 3);
      chk("load0_done", sw.done, 1);
      tick(1);
      chk("load0_done_end", sw.done, 0);
      sw.clear = 1; tick(1); sw.clear = 0;

      sw.start = 1; tick(1); sw.start = 0;
      tick(149);
      chk("up_14", sw.count, 14);
      tick(1);
      chk("up_term", sw.count, 15);
      chk("up_term_st", sw.status, 3);
      chk("up_term_done", sw.done, 1);
      sw.lap = 1; tick(1); sw.lap = 0;
      chk("done_lap", sw.lap_valid, 0);
      sw.clear = 1; tick(1); sw.clear = 0;

      sw.start = 1; tick(1); sw.start = 0;
      tick(25);
      sw.lap = 1; tick(1); sw.lap = 0;
      chk("lap_val2", sw.lap_val, 2);
      tick(1);
      #2 rst = 1;
      #1;
      chk("arst_status", sw.status, 0);
      chk("arst_count", sw.count, 0);
      chk("arst_lap_val", sw.lap_val, 0);
      chk("arst_cen", sw.c_enable, 0);
      chk("arst_done", sw.done, 0);
      chk("arst_lapv", sw.lap_valid, 0);
      @(negedge clk);
      rst = 0;

      for (int i = 0; i < 3000; i++) begin
         sw.start = ($urandom_range(0, 7) == 0);
         sw.stop  = ((i % 600) < 300) ? ($urandom_range(0, 9) == 0)
                                      : ($urandom_range(0, 199) == 0);
         sw.clear = ($urandom_range(0, 9) == 0);
         sw.lap   = ($urandom_range(0, 5) == 0);
         sw.down_mode = 1'($urandom_range(0, 1));
         sw.load_val  = ($urandom_range(0, 3) == 0) ? '0 :
                        CW'($urandom_range(1, MAXC));
         if ($urandom_range(0, 299) == 0) begin
            #2 rst = 1;
            #2 rst = 0;
         end
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
